control_pipeline: RTL and testbench

- Consumes the per-instruction control buses produced by the ID-stage control decoder (execute 7b, memory 3b, write-back 2b).
- Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers, each stage drawing its own slice.
- Detects load-use hazards, generates forwarding selects, injects bubbles on stall/flush and counts retired instructions for the debug unit.

---
 rtl/control_pipeline.sv | 179 +++++++++++++++++
 tb/tb_control_pipeline.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
// control_pipeline: carries decoder control buses through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, selects ALU forwarding sources, injects
// bubbles on stall/flush and counts retired instructions.
module control_pipeline #(
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [EXEC_BUS_WIDTH-1:0] id_exec_bus,
  input  logic [MEM_BUS_WIDTH-1:0]  id_mem_bus,
  input  logic [WB_BUS_WIDTH-1:0]   id_wb_bus,
  input  logic [4:0]                id_rs,
  input  logic [4:0]                id_rt,
  input  logic [4:0]                id_rd,
  output logic [EXEC_BUS_WIDTH-1:0] ex_exec_bus,
  output logic [4:0]                ex_rs,
  output logic [4:0]                ex_rt,
  output logic [MEM_BUS_WIDTH-1:0]  mem_mem_bus,
  output logic [WB_BUS_WIDTH-1:0]   wb_wb_bus,
  output logic [4:0]                wb_write_addr,
  output logic                      stall,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b,
  output logic [COUNT_WIDTH-1:0]    retired_count
);

  // Bubble execute word: alu_op all ones, every flag clear.
  localparam logic [EXEC_BUS_WIDTH-1:0] EXEC_BUBBLE = EXEC_BUS_WIDTH'(7'h0F);

  // ID/EX
  logic [EXEC_BUS_WIDTH-1:0] ex_exec_q, ex_exec_d;
  logic [MEM_BUS_WIDTH-1:0]  ex_mem_q, ex_mem_d;
  logic [WB_BUS_WIDTH-1:0]   ex_wb_q, ex_wb_d;
  logic                      ex_valid_q, ex_valid_d;
  logic [4:0]                ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  // EX/MEM
  logic [MEM_BUS_WIDTH-1:0]  mem_mem_q, mem_mem_d;
  logic [WB_BUS_WIDTH-1:0]   mem_wb_q, mem_wb_d;
  logic                      mem_valid_q, mem_valid_d;
  logic [4:0]                mem_dst_q, mem_dst_d;
  // MEM/WB
  logic [WB_BUS_WIDTH-1:0]   wb_wb_q, wb_wb_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [4:0]                wb_addr_q, wb_addr_d;
  logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic       stall_w;
  logic [4:0] ex_dst_w;

  // Select the freshest producer: EX/MEM beats MEM/WB; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_rw, input logic [4:0] mem_dst,
                                         input logic wb_rw, input logic [4:0] wb_dst);
    if (mem_rw && (mem_dst != 5'd0) && (mem_dst == src))
      return 2'b10;
    else if (wb_rw && (wb_dst != 5'd0) && (wb_dst == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ex_dst_w = ex_exec_q[5] ? ex_rd_q : ex_rt_q;

  // A load in EX whose target is read by the ID instruction; a flush overrides it.
  assign stall_w = id_valid & ex_mem_q[1] & (ex_rt_q != 5'd0) &
                   ((ex_rt_q == id_rs) | (ex_rt_q == id_rt)) & ~flush;

  // Next state with priority !enable > flush > stall > normal.
  always_comb begin
    ex_exec_d   = ex_exec_q;
    ex_mem_d    = ex_mem_q;
    ex_wb_d     = ex_wb_q;
    ex_valid_d  = ex_valid_q;
    ex_rs_d     = ex_rs_q;
    ex_rt_d     = ex_rt_q;
    ex_rd_d     = ex_rd_q;
    mem_mem_d   = mem_mem_q;
    mem_wb_d    = mem_wb_q;
    mem_valid_d = mem_valid_q;
    mem_dst_d   = mem_dst_q;
    wb_wb_d     = wb_wb_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    cnt_d       = cnt_q;
    if (enable) begin
      if (wb_valid_q)
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      // MEM/WB always advances on an enabled edge
      wb_wb_d    = mem_wb_q;
      wb_valid_d = mem_valid_q;
      wb_addr_d  = mem_dst_q;
      if (flush) begin
        mem_mem_d   = '0;
        mem_wb_d    = '0;
        mem_valid_d = 1'b0;
        mem_dst_d   = '0;
      end else begin
        // EX/MEM takes the ID/EX contents
        mem_mem_d   = ex_mem_q;
        mem_wb_d    = ex_wb_q;
        mem_valid_d = ex_valid_q;
        mem_dst_d   = ex_dst_w;
      end
      if (!flush && !stall_w && id_valid) begin
        // ID/EX loads the decoder outputs
        ex_exec_d  = id_exec_bus;
        ex_mem_d   = id_mem_bus;
        ex_wb_d    = id_wb_bus;
        ex_valid_d = 1'b1;
        ex_rs_d    = id_rs;
        ex_rt_d    = id_rt;
        ex_rd_d    = id_rd;
      end else begin
        ex_exec_d  = EXEC_BUBBLE;
        ex_mem_d   = '0;
        ex_wb_d    = '0;
        ex_valid_d = 1'b0;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_rd_d    = '0;
      end
    end
  end

  // Stage registers and counter; reset fills every stage with a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_exec_q   <= EXEC_BUBBLE;
      ex_mem_q    <= '0;
      ex_wb_q     <= '0;
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      mem_mem_q   <= '0;
      mem_wb_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= '0;
      wb_wb_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      cnt_q       <= '0;
    end else begin
      ex_exec_q   <= ex_exec_d;
      ex_mem_q    <= ex_mem_d;
      ex_wb_q     <= ex_wb_d;
      ex_valid_q  <= ex_valid_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rd_q     <= ex_rd_d;
      mem_mem_q   <= mem_mem_d;
      mem_wb_q    <= mem_wb_d;
      mem_valid_q <= mem_valid_d;
      mem_dst_q   <= mem_dst_d;
      wb_wb_q     <= wb_wb_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_exec_bus   = ex_exec_q;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign mem_mem_bus   = mem_mem_q;
  assign wb_wb_bus     = wb_wb_q;
  assign wb_write_addr = wb_addr_q;
  assign stall         = stall_w;
  assign forward_a     = fwd_sel(ex_rs_q, mem_wb_q[1], mem_dst_q, wb_wb_q[1], wb_addr_q);
  assign forward_b     = fwd_sel(ex_rt_q, mem_wb_q[1], mem_dst_q, wb_wb_q[1], wb_addr_q);
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Testbench for control_pipeline: directed scenarios plus random traffic,
// checked against an instruction-level model of the three pipeline slots.
module tb_control_pipeline;

  logic        clk = 1'b0;
  logic        reset, enable, flush, id_valid;
  logic [6:0]  id_exec_bus;
  logic [2:0]  id_mem_bus;
  logic [1:0]  id_wb_bus;
  logic [4:0]  id_rs, id_rt, id_rd;

  logic [6:0]  ex_exec_bus;
  logic [4:0]  ex_rs, ex_rt, wb_write_addr;
  logic [2:0]  mem_mem_bus;
  logic [1:0]  wb_wb_bus, forward_a, forward_b;
  logic        stall;
  logic [31:0] retired_count;

  logic [6:0]  d4_exec;
  logic [4:0]  d4_rs, d4_rt, d4_waddr;
  logic [2:0]  d4_mem;
  logic [1:0]  d4_wb, d4_fa, d4_fb;
  logic        d4_stall;
  logic [3:0]  d4_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_pipeline dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .id_valid(id_valid),
    .id_exec_bus(id_exec_bus), .id_mem_bus(id_mem_bus), .id_wb_bus(id_wb_bus),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_exec_bus(ex_exec_bus), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_mem_bus(mem_mem_bus),
    .wb_wb_bus(wb_wb_bus), .wb_write_addr(wb_write_addr), .stall(stall),
    .forward_a(forward_a), .forward_b(forward_b), .retired_count(retired_count)
  );

  control_pipeline #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .id_valid(id_valid),
    .id_exec_bus(id_exec_bus), .id_mem_bus(id_mem_bus), .id_wb_bus(id_wb_bus),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_exec_bus(d4_exec), .ex_rs(d4_rs), .ex_rt(d4_rt), .mem_mem_bus(d4_mem),
    .wb_wb_bus(d4_wb), .wb_write_addr(d4_waddr), .stall(d4_stall),
    .forward_a(d4_fa), .forward_b(d4_fb), .retired_count(d4_count)
  );

  // One in-flight instruction; the model is three slots holding these.
  typedef struct packed {
    logic       v;
    logic [6:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] rs, rt, rd;
  } instr_t;

  instr_t      m_ex, m_mem, m_wb;
  logic [31:0] retired;

  function automatic instr_t bubble();
    instr_t b;
    b = '0;
    b.ex = 7'h0F;
    return b;
  endfunction

  function automatic logic [4:0] dst_of(instr_t i);
    return i.ex[5] ? i.rd : i.rt;
  endfunction

  function automatic logic exp_stall();
    return id_valid && m_ex.mem[1] && (m_ex.rt != 5'd0) &&
           ((m_ex.rt == id_rs) || (m_ex.rt == id_rt)) && !flush;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] src);
    if (m_mem.wb[1] && dst_of(m_mem) != 5'd0 && dst_of(m_mem) == src) return 2'b10;
    if (m_wb.wb[1] && dst_of(m_wb) != 5'd0 && dst_of(m_wb) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); retired = 32'd0;
  endtask

  task automatic model_edge();
    instr_t nxt;
    logic st;
    if (!enable) return;
    st = exp_stall();
    if (m_wb.v) retired = retired + 32'd1;
    m_wb = m_mem;
    if (flush) begin
      m_mem = bubble(); m_ex = bubble();
    end else if (st) begin
      m_mem = m_ex; m_ex = bubble();
    end else begin
      m_mem = m_ex;
      if (id_valid) begin
        nxt.v = 1'b1; nxt.ex = id_exec_bus; nxt.mem = id_mem_bus; nxt.wb = id_wb_bus;
        nxt.rs = id_rs; nxt.rt = id_rt; nxt.rd = id_rd;
        m_ex = nxt;
      end else begin
        m_ex = bubble();
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ex_exec", 32'(ex_exec_bus), 32'(m_ex.ex));
    chk("ex_rs", 32'(ex_rs), 32'(m_ex.rs));
    chk("ex_rt", 32'(ex_rt), 32'(m_ex.rt));
    chk("mem_bus", 32'(mem_mem_bus), 32'(m_mem.mem));
    chk("wb_bus", 32'(wb_wb_bus), 32'(m_wb.wb));
    chk("wb_addr", 32'(wb_write_addr), 32'(dst_of(m_wb)));
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("fwd_a", 32'(forward_a), 32'(exp_fwd(m_ex.rs)));
    chk("fwd_b", 32'(forward_b), 32'(exp_fwd(m_ex.rt)));
    chk("count", retired_count, retired);
    chk("count4", 32'(d4_count), 32'(retired[3:0]));
    chk("d4_exec", 32'(d4_exec), 32'(m_ex.ex));
    chk("d4_stall", 32'(d4_stall), 32'(exp_stall()));
    chk("d4_fwd", 32'({d4_fa, d4_fb}), 32'({exp_fwd(m_ex.rs), exp_fwd(m_ex.rt)}));
    chk("d4_out", 32'({d4_rs, d4_rt, d4_mem, d4_wb, d4_waddr}),
        32'({m_ex.rs, m_ex.rt, m_mem.mem, m_wb.wb, dst_of(m_wb)}));
  endtask

  // Called one time unit after a rising edge with the inputs already set.
  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv(logic v, logic [6:0] ex, logic [2:0] mem, logic [1:0] wb,
                     logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    id_valid = v; id_exec_bus = ex; id_mem_bus = mem; id_wb_bus = wb;
    id_rs = rs; id_rt = rt; id_rd = rd;
    flush = 1'b0; enable = 1'b1;
  endtask

  task automatic idle();
    drv(1'b0, 7'h00, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  // Asynchronous reset pulse in the middle of a clock phase.
  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_exec", 32'(ex_exec_bus), 32'h0F);
    chk("rst_mem", 32'(mem_mem_bus), 32'h0);
    chk("rst_wb", 32'(wb_wb_bus), 32'h0);
    chk("rst_cnt", retired_count, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    #1 reset = 1'b0;
  endtask

  task automatic drain(int n);
    idle();
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #3;
    chk("por_exec", 32'(ex_exec_bus), 32'h0F);
    chk("por_addr", 32'(wb_write_addr), 32'h0);
    chk("por_cnt", retired_count, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Pass-through of an addu to rd=5
    drv(1'b1, 7'h23, 3'b000, 2'b10, 5'd1, 5'd2, 5'd5);
    cyc();
    chk("pt_ex", 32'(ex_exec_bus), 32'h23);
    idle();
    cyc();
    cyc();
    chk("pt_wb", 32'(wb_wb_bus), 32'h2);
    chk("pt_addr", 32'(wb_write_addr), 32'd5);
    chk("pt_cnt0", retired_count, 32'd0);
    cyc();
    chk("pt_cnt1", retired_count, 32'd1);

    // Load-use: lw rt=8 then add rs=8
    drv(1'b1, 7'h10, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    cyc();
    #1 chk("lu_bubble", 32'(ex_exec_bus), 32'h0F);
    chk("lu_unstall", 32'(stall), 32'd0);
    cyc();
    chk("lu_add_ex", 32'(ex_exec_bus), 32'h22);
    idle();
    cyc();
    cyc();
    chk("lu_add_wb", 32'(wb_write_addr), 32'd10);
    drain(2);

    // Load to $0 never stalls
    drv(1'b1, 7'h10, 3'b010, 2'b11, 5'd1, 5'd0, 5'd0);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd0, 5'd0, 5'd10);
    #1 chk("lu0_stall", 32'(stall), 32'd0);
    cyc();
    drain(3);

    // Forwarding from EX/MEM
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd3, 5'd3, 5'd4);
    cyc();
    idle();
    #1 chk("fw_mem", 32'({forward_a, forward_b}), 32'b1010);
    drain(3);

    // Forwarding from MEM/WB with one unrelated instruction between
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd1, 5'd2, 5'd6);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd3, 5'd3, 5'd4);
    cyc();
    idle();
    #1 chk("fw_wb", 32'({forward_a, forward_b}), 32'b0101);
    drain(3);

    // Both stages write $3: EX/MEM wins
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd4, 5'd5, 5'd3);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd3, 5'd3, 5'd4);
    cyc();
    idle();
    #1 chk("fw_dbl", 32'({forward_a, forward_b}), 32'b1010);
    drain(3);

    // Flush while a load-use condition is present
    drv(1'b1, 7'h25, 3'b000, 2'b10, 5'd1, 5'd2, 5'd7);
    cyc();
    drv(1'b1, 7'h10, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    flush = 1'b1;
    #1 chk("fl_stall", 32'(stall), 32'd0);
    cyc();
    flush = 1'b0;
    chk("fl_ex", 32'(ex_exec_bus), 32'h0F);
    chk("fl_mem", 32'(mem_mem_bus), 32'h0);
    chk("fl_wb", 32'(wb_write_addr), 32'd7);
    drain(3);

    // Reset while stalled
    drv(1'b1, 7'h10, 3'b010, 2'b11, 5'd1, 5'd8, 5'd0);
    cyc();
    drv(1'b1, 7'h22, 3'b000, 2'b10, 5'd8, 5'd9, 5'd10);
    #1 chk("rs_stall", 32'(stall), 32'd1);
    async_reset();
    drain(2);

    // Freeze for 5 cycles with a loaded pipeline
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 7'($urandom), 3'b000, 2'b10, 5'($urandom), 5'($urandom), 5'($urandom));
      cyc();
    end
    enable = 1'b0;
    begin
      logic [6:0] f_ex;
      logic [4:0] f_addr;
      logic [31:0] f_cnt;
      f_ex = m_ex.ex; f_addr = dst_of(m_wb); f_cnt = retired;
      for (int i = 0; i < 5; i++) begin
        cyc();
        chk("frz_ex", 32'(ex_exec_bus), 32'(f_ex));
        chk("frz_addr", 32'(wb_write_addr), 32'(f_addr));
        chk("frz_cnt", retired_count, f_cnt);
      end
    end
    drain(4);

    // Sixteen retirements wrap the 4-bit counter
    async_reset();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 7'($urandom), 3'b000, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      cyc();
    end
    drain(4);
    chk("wrap4", 32'(d4_count), 32'd0);
    chk("wrap32", retired_count, 32'd16);

    // Random traffic with occasional flush, freeze and reset
    for (int i = 0; i < 600; i++) begin
      drv(1'($urandom), 7'($urandom), 3'($urandom), 2'($urandom),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      flush  = ($urandom_range(0, 7) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 99) == 0) async_reset();
      cyc();
    end
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
